// File: rtl/alu_sched_pkg.sv
// rtl/alu_sched_pkg.sv - opcode, state encodings and ALU drive helpers for alu_scheduler
package alu_sched_pkg;

  typedef enum logic [1:0] {
    OP_ADD8 = 2'b00,
    OP_SUB8 = 2'b01,
    OP_MUL4 = 2'b10,
    OP_INC8 = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LO   = 2'b01,
    ST_HI   = 2'b10,
    ST_RESP = 2'b11
  } state_t;

  // B operand for one nibble pass: subtract uses the inverted Y nibble, increment adds zero
  function automatic logic [3:0] alu_b_nib(op_t op, logic [3:0] y);
    case (op)
      OP_SUB8: return ~y;
      OP_INC8: return 4'h0;
      default: return y;
    endcase
  endfunction

  // carry-in of the low pass: +1 completes the two's complement for SUB, is the +1 for INC
  function automatic logic lo_cin(op_t op);
    return (op == OP_SUB8) || (op == OP_INC8);
  endfunction

endpackage

// File: rtl/alu_scheduler_if.sv
// rtl/alu_scheduler_if.sv - request, ALU and response signal bundle of alu_scheduler
interface alu_scheduler_if;

  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [1:0] req_op0;
  logic [1:0] req_op1;
  logic [7:0] req_x0;
  logic [7:0] req_y0;
  logic [7:0] req_x1;
  logic [7:0] req_y1;

  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic       alu_cin;
  logic [3:0] alu_out1;
  logic       alu_cout;
  logic [7:0] alu_out2;

  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [7:0] rsp_data;
  logic       rsp_carry;
  logic       busy;

  // requesters, ALU and response consumer
  modport master (
    output req_valid, req_op0, req_op1, req_x0, req_y0, req_x1, req_y1,
    output alu_out1, alu_cout, alu_out2, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_cin,
    input  rsp_valid, rsp_id, rsp_data, rsp_carry, busy
  );

  // the scheduler itself
  modport slave (
    input  req_valid, req_op0, req_op1, req_x0, req_y0, req_x1, req_y1,
    input  alu_out1, alu_cout, alu_out2, rsp_ready,
    output req_ready, alu_a, alu_b, alu_cin,
    output rsp_valid, rsp_id, rsp_data, rsp_carry, busy
  );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin arbiter
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       enable,
  output logic [1:0] grant
);

  // on a tie the requester not granted last time wins; a lone requester always wins
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (req == 2'b11) grant = last ? 2'b01 : 2'b10;
      else              grant = req;
    end
  end

endmodule

// File: rtl/alu_scheduler.sv
// rtl/alu_scheduler.sv - arbitrates two requesters onto the shared 4-bit ALU and sequences 8-bit ops
module alu_scheduler
  import alu_sched_pkg::*;
(
  input logic            clk,
  input logic            rst,
  alu_scheduler_if.slave bus
);

  state_t     state;
  op_t        op_q;
  logic [3:0] x_hi;
  logic [3:0] y_hi;
  logic       last;
  logic [1:0] grant;

  logic [3:0] alu_a_q;
  logic [3:0] alu_b_q;
  logic       alu_cin_q;
  logic       valid_q;
  logic       id_q;
  logic [7:0] data_q;
  logic       carry_q;
  logic       busy_q;

  op_t        sel_op;
  logic [7:0] sel_x;
  logic [7:0] sel_y;

  rr_arb2 u_arb (
    .req    (bus.req_valid),
    .last   (last),
    .enable ((state == ST_IDLE) && !rst),
    .grant  (grant)
  );

  // operands of whichever requester is granted this cycle
  always_comb begin
    sel_op = grant[1] ? op_t'(bus.req_op1) : op_t'(bus.req_op0);
    sel_x  = grant[1] ? bus.req_x1 : bus.req_x0;
    sel_y  = grant[1] ? bus.req_y1 : bus.req_y0;
  end

  // sequencer: the ALU drive for the next pass is registered one edge ahead so it is
  // stable for the whole LO/HI cycle; alu_cin_q doubles as the inter-pass carry register
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      op_q      <= OP_ADD8;
      x_hi      <= 4'h0;
      y_hi      <= 4'h0;
      last      <= 1'b1;
      alu_a_q   <= 4'h0;
      alu_b_q   <= 4'h0;
      alu_cin_q <= 1'b0;
      valid_q   <= 1'b0;
      id_q      <= 1'b0;
      data_q    <= 8'h00;
      carry_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|grant) begin
            op_q      <= sel_op;
            x_hi      <= sel_x[7:4];
            y_hi      <= sel_y[7:4];
            id_q      <= grant[1];
            last      <= grant[1];
            alu_a_q   <= sel_x[3:0];
            alu_b_q   <= alu_b_nib(sel_op, sel_y[3:0]);
            alu_cin_q <= lo_cin(sel_op);
            busy_q    <= 1'b1;
            state     <= ST_LO;
          end
        end
        ST_LO: begin
          if (op_q == OP_MUL4) begin
            data_q    <= bus.alu_out2;
            carry_q   <= 1'b0;
            valid_q   <= 1'b1;
            alu_a_q   <= 4'h0;
            alu_b_q   <= 4'h0;
            alu_cin_q <= 1'b0;
            state     <= ST_RESP;
          end else begin
            data_q[3:0] <= bus.alu_out1;
            alu_a_q     <= x_hi;
            alu_b_q     <= alu_b_nib(op_q, y_hi);
            alu_cin_q   <= bus.alu_cout;
            state       <= ST_HI;
          end
        end
        ST_HI: begin
          data_q[7:4] <= bus.alu_out1;
          carry_q     <= bus.alu_cout;
          valid_q     <= 1'b1;
          alu_a_q     <= 4'h0;
          alu_b_q     <= 4'h0;
          alu_cin_q   <= 1'b0;
          state       <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready = grant;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_cin   = alu_cin_q;
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_carry = carry_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_alu_scheduler.sv
// tb/tb_alu_scheduler.sv - scoreboard bench for alu_scheduler with a behavioural 4-bit ALU
module tb_alu_scheduler;
  import alu_sched_pkg::*;

  typedef struct {
    bit         id;
    logic [7:0] data;
    logic       carry;
    int         acc;
    bit         mul;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  bit   acc_ids[$];

  alu_scheduler_if ifc ();

  alu_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // the shared ALU the scheduler drives
  assign {ifc.alu_cout, ifc.alu_out1} = {1'b0, ifc.alu_a} + {1'b0, ifc.alu_b} + {4'b0, ifc.alu_cin};
  assign ifc.alu_out2 = {4'b0, ifc.alu_a} * {4'b0, ifc.alu_b};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference result {carry, data} computed on whole 8-bit values
  function automatic logic [8:0] model(op_t op, logic [7:0] x, logic [7:0] y);
    logic [7:0] p;
    case (op)
      OP_ADD8: model = {1'b0, x} + {1'b0, y};
      OP_SUB8: model = {(x >= y), x - y};
      OP_MUL4: begin
        p = {4'b0, x[3:0]} * {4'b0, y[3:0]};
        model = {1'b0, p};
      end
      default: model = {1'b0, x} + 9'd1;
    endcase
  endfunction

  // present a command on requester g until accepted; returns just after the accept edge
  task automatic send(input bit g, input op_t op, input logic [7:0] x, input logic [7:0] y);
    int n = 0;
    bit got = 0;
    logic [8:0] r;
    if (g) begin
      ifc.req_op1 = op; ifc.req_x1 = x; ifc.req_y1 = y;
    end else begin
      ifc.req_op0 = op; ifc.req_x0 = x; ifc.req_y0 = y;
    end
    ifc.req_valid[g] = 1'b1;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      if (ifc.req_ready[g] && !rst) begin
        got = 1;
        r = model(op, x, y);
        sb.push_back('{id: g, data: r[7:0], carry: r[8], acc: cyc, mul: (op == OP_MUL4)});
        acc_ids.push_back(g);
      end
    end
    chk("accept", 32'(got), 1);
    if (got) begin
      @(posedge clk);
      #1;
    end
    ifc.req_valid[g] = 1'b0;
    if (g) begin
      ifc.req_x1 = 8'($urandom); ifc.req_y1 = 8'($urandom); ifc.req_op1 = 2'($urandom);
    end else begin
      ifc.req_x0 = 8'($urandom); ifc.req_y0 = 8'($urandom); ifc.req_op0 = 2'($urandom);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || ifc.rsp_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(sb.size()), 0);
    @(posedge clk);
    #1;
  endtask

  // response side: latency on each rising Rsp_Valid, payload on each handshake
  task automatic monitor();
    bit   prev = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      chk("ready_onehot", 32'($countones(ifc.req_ready) <= 1), 1);
      if (ifc.rsp_valid && !prev) begin
        if (sb.size() == 0) chk("unexpected_rsp", 32'(ifc.rsp_valid), 0);
        else chk("latency", 32'(cyc - sb[0].acc), sb[0].mul ? 2 : 3);
      end
      if (ifc.rsp_valid && ifc.rsp_ready && sb.size() != 0) begin
        e = sb.pop_front();
        chk("rsp_id", 32'(ifc.rsp_id), 32'(e.id));
        chk("rsp_data", 32'(ifc.rsp_data), 32'(e.data));
        chk("rsp_carry", 32'(ifc.rsp_carry), 32'(e.carry));
      end
      prev = ifc.rsp_valid;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    ifc.req_valid = 2'b11;
    ifc.req_op0 = OP_ADD8; ifc.req_x0 = 8'h12; ifc.req_y0 = 8'h34;
    ifc.req_op1 = OP_SUB8; ifc.req_x1 = 8'h56; ifc.req_y1 = 8'h78;
    ifc.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(ifc.req_ready), 0);
    chk("rst_rsp_valid", 32'(ifc.rsp_valid), 0);
    chk("rst_rsp_data", 32'(ifc.rsp_data), 0);
    chk("rst_rsp_id", 32'(ifc.rsp_id), 0);
    chk("rst_rsp_carry", 32'(ifc.rsp_carry), 0);
    chk("rst_busy", 32'(ifc.busy), 0);
    chk("rst_alu", 32'({ifc.alu_a, ifc.alu_b, ifc.alu_cin}), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ifc.req_valid = 2'b00;
    fork
      monitor();
    join_none

    // both requesters continuously valid: grants must alternate starting with 0
    acc_ids.delete();
    fork
      for (int i = 0; i < 4; i++) send(1'b0, op_t'(2'($urandom_range(0, 3))), 8'($urandom), 8'($urandom));
      for (int j = 0; j < 4; j++) send(1'b1, op_t'(2'($urandom_range(0, 3))), 8'($urandom), 8'($urandom));
    join
    drain();
    chk("rr_count", 32'(acc_ids.size()), 8);
    for (int k = 0; k < acc_ids.size(); k++) chk("rr_order", 32'(acc_ids[k]), 32'(k % 2));

    // ADD8 0x9C + 0x75: low nibble carries into the high pass
    send(1'b0, OP_ADD8, 8'h9C, 8'h75);
    chk("add_lo_drive", 32'({ifc.alu_a, ifc.alu_b, ifc.alu_cin}), 32'({4'hC, 4'h5, 1'b0}));
    @(posedge clk);
    #1;
    chk("add_hi_drive", 32'({ifc.alu_a, ifc.alu_b, ifc.alu_cin}), 32'({4'h9, 4'h7, 1'b1}));
    drain();

    // SUB8 with and without borrow
    send(1'b1, OP_SUB8, 8'h10, 8'h20);
    chk("sub_lo_drive", 32'({ifc.alu_a, ifc.alu_b, ifc.alu_cin}), 32'({4'h0, 4'hF, 1'b1}));
    drain();
    send(1'b1, OP_SUB8, 8'h20, 8'h10);
    drain();

    // MUL4 uses only the low nibbles
    send(1'b0, OP_MUL4, 8'hAF, 8'h3D);
    chk("mul_lo_drive", 32'({ifc.alu_a, ifc.alu_b, ifc.alu_cin}), 32'({4'hF, 4'hD, 1'b0}));
    drain();

    // mixed random traffic
    for (int i = 0; i < 10; i++)
      send(1'($urandom_range(0, 1)), op_t'(2'($urandom_range(0, 3))), 8'($urandom), 8'($urandom));
    drain();

    // backpressure: response held 5 cycles while requester 1 waits
    ifc.rsp_ready = 1'b0;
    send(1'b0, OP_ADD8, 8'h80, 8'h80);
    fork
      send(1'b1, OP_INC8, 8'h41, 8'h00);
      begin
        n = 0;
        while (!ifc.rsp_valid && n < 20) begin
          @(negedge clk);
          n++;
        end
        chk("bp_seen", 32'(ifc.rsp_valid), 1);
        repeat (5) begin
          @(negedge clk);
          chk("bp_hold", 32'({ifc.rsp_valid, ifc.rsp_id, ifc.rsp_carry, ifc.rsp_data}), 32'({1'b1, 1'b0, 1'b1, 8'h00}));
          chk("bp_req_ready", 32'(ifc.req_ready), 0);
        end
        @(posedge clk);
        #1;
        ifc.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_idle", 32'({ifc.busy, ifc.rsp_valid}), 0);
      end
    join
    drain();

    // reset during the HI pass of INC8 0xFF aborts it silently
    ifc.req_op0 = OP_INC8; ifc.req_x0 = 8'hFF; ifc.req_y0 = 8'h00;
    ifc.req_valid[0] = 1'b1;
    @(negedge clk);
    chk("abort_accept", 32'(ifc.req_ready[0]), 1);
    @(posedge clk);
    #1;
    ifc.req_valid[0] = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy_hi", 32'(ifc.busy), 1);
    rst = 1'b1;
    ifc.req_valid = 2'b11;
    @(posedge clk);
    #1;
    chk("abort_idle", 32'({ifc.busy, ifc.rsp_valid}), 0);
    @(negedge clk);
    chk("abort_rst_ready", 32'(ifc.req_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ifc.req_valid = 2'b00;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_rsp", 32'(ifc.rsp_valid), 0);
    end
    @(posedge clk);
    #1;

    // after reset the tie goes to requester 0 again, and INC8 0xFF wraps with carry
    acc_ids.delete();
    fork
      send(1'b0, OP_INC8, 8'hFF, 8'h00);
      send(1'b1, OP_ADD8, 8'h03, 8'h04);
    join
    drain();
    chk("post_rst_count", 32'(acc_ids.size()), 2);
    if (acc_ids.size() == 2) begin
      chk("post_rst_first", 32'(acc_ids[0]), 0);
      chk("post_rst_second", 32'(acc_ids[1]), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_scheduler.md
# alu_scheduler

Sequencer and two-port arbiter for the shared 4-bit ALU datapath (ripple adder plus 4-bit multiplier). Two requesters issue 8-bit operations over valid/ready handshakes. The block grants one at a time, round-robin, and breaks each operation into one or two 4-bit ALU passes by driving A/B/Cin and sampling Out1/Cout/Out2. It chains the carry between passes and returns a registered 8-bit result plus carry, tagged with the requester ID.

## Interface
Parameters:
- none. Widths are fixed by the 4-bit ALU: nibble 4, operand 8, product 8.

Ports:
- Clk  in  1  clock. All state updates on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- Req_Valid  in  2  per-requester command valid (bit i = requester i).
- Req_Ready  out  2  per-requester accept. At most one bit is high.
- Req_Op0, Req_Op1  in  2 each  opcode: 00 ADD8, 01 SUB8, 10 MUL4, 11 INC8.
- Req_X0, Req_Y0, Req_X1, Req_Y1  in  8 each  operands.
- Alu_A, Alu_B  out  4 each  drive the ALU A/B inputs.
- Alu_Cin  out  1  drives the ALU Cin input.
- Alu_Out1  in  4  ALU sum.
- Alu_Cout  in  1  ALU carry out.
- Alu_Out2  in  8  ALU product.
- Rsp_Valid  out  1  result valid.
- Rsp_Ready  in  1  consumer accepts the result.
- Rsp_Id  out  1  requester the result belongs to.
- Rsp_Data  out  8  result.
- Rsp_Carry  out  1  carry / no-borrow flag.
- Busy  out  1  high in any state other than IDLE.

## Operation
- The FSM has four states: IDLE, LO, HI, RESP.
- **IDLE**
  - Arbitrate between the requesters.
  - Req_Ready[g] = 1 only for the granted requester g whose Req_Valid is high.
  - On accept, latch op, X, Y and g, then go to LO.
- **Arbitration**
  - A 1-bit pointer Last records the last granted requester.
  - If both requesters are valid, grant !Last. Otherwise grant whichever is valid.
  - Last updates only on accept.
- **LO** (low-nibble pass); Alu_A = X[3:0]
  - ADD8: Alu_B = Y[3:0], Alu_Cin = 0.
  - SUB8: Alu_B = ~Y[3:0], Alu_Cin = 1.
  - INC8: Alu_B = 0, Alu_Cin = 1.
  - MUL4: Alu_B = Y[3:0], Alu_Cin = 0.
  - At the clock edge:
    - MUL4: register Alu_Out2 into Rsp_Data, set Rsp_Carry = 0, go to RESP.
    - Other ops: register Alu_Out1 into Data[3:0] and Alu_Cout into carry register C, go to HI.
- **HI** (high-nibble pass); Alu_A = X[7:4], Alu_Cin = C
  - ADD8: Alu_B = Y[7:4].
  - SUB8: Alu_B = ~Y[7:4].
  - INC8: Alu_B = 0.
  - At the clock edge, register Alu_Out1 into Data[7:4] and Alu_Cout into Rsp_Carry, then go to RESP.
- **RESP**
  - Rsp_Valid = 1, with Rsp_Data, Rsp_Id and Rsp_Carry held stable.
  - When Rsp_Ready is high, go to IDLE.
- **Arithmetic rules**
  - All results are modulo 256.
  - SUB8 Rsp_Carry = 1 means no borrow (X >= Y).
  - MUL4 ignores X[7:4] and Y[7:4].
  - INC8 ignores Y.
- **ALU drive outside LO/HI:** Alu_A, Alu_B and Alu_Cin are driven to 0 in IDLE and RESP.

## Timing
- **Reset values:** state IDLE, Last = 1 (requester 0 wins the first tie), Req_Ready = 0, Rsp_Valid = 0, Rsp_Data = 0, Rsp_Id = 0, Rsp_Carry = 0, Busy = 0, Alu_* = 0.
- **Accept:** at edge t, when Req_Valid & Req_Ready.
- **Result latency** (assuming Rsp_Ready is held high):
  - ADD8/SUB8/INC8: Rsp_Valid is visible in cycle t+3 (LO at t+1, HI at t+2).
  - MUL4: Rsp_Valid is visible in cycle t+2.
- **Throughput:** Req_Ready is high only in IDLE, so the earliest next accept is the cycle after Rsp_Valid && Rsp_Ready.
  - Add-class ops: 4 cycles per operation.
  - MUL4: 3 cycles per operation.
- **Backpressure:** Rsp_Valid stays high and Rsp_* stay constant until Rsp_Ready is seen, with no limit on duration.
- **Input changes:** requester inputs may change at any time after the accept edge. Only latched copies are used.
- **Reset mid-operation:** Rst asserted in LO, HI or RESP returns the block to IDLE at the next edge. No response is produced for the aborted operation, and Last returns to 1.
- **Reset with valid request:** Req_Valid high during Rst is not accepted. Req_Ready is 0 while Rst is high.

## Structure
- Package alu_sched_pkg holds:
  - the opcode constants OP_ADD8, OP_SUB8, OP_MUL4, OP_INC8;
  - the FSM state encoding for IDLE, LO, HI, RESP.
- Sub-module rr_arb2 (two-requester round-robin arbiter): inputs Req[1:0], Last and Enable; outputs Grant[1:0] (one-hot or zero).
- The top level instantiates rr_arb2. In the testbench it connects to an ALU instance; inside the block the ALU is not instantiated.

## Test plan
- Req0 ADD8 X=0x9C, Y=0x75, Rsp_Ready=1 → Rsp_Data=0x11, Rsp_Carry=1, Rsp_Id=0, Rsp_Valid in cycle t+3. Alu_Cin=1 in HI (low nibble C+5 carries).
- Req1 SUB8 X=0x10, Y=0x20 → Rsp_Data=0xF0, Rsp_Carry=0. Then SUB8 X=0x20, Y=0x10 → 0x10, Rsp_Carry=1.
- Req0 MUL4 X=0xAF, Y=0x3D (uses F×D) → Rsp_Data=0xC3, Rsp_Carry=0, Rsp_Valid in cycle t+2.
- Both requesters valid continuously, four ops each → grants alternate 0,1,0,1…, starting with 0. No request is starved.
- Rsp_Ready held low 5 cycles → Rsp_* stable, both Req_Ready stay 0. Accept on release, IDLE next cycle.
- Rst asserted in HI of INC8 X=0xFF → no Rsp_Valid. The next request after reset is processed normally (INC8 0xFF → 0x00, Rsp_Carry=1).
